control_signals: RTL and testbench

//  Microinstruction decoder/register for the multicore processor control unit.

---
 rtl/control_signals_if.sv | 22 ++
 rtl/control_signals.sv | 74 +++++++
 tb/tb_control_signals.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/control_signals_if.sv
// Microinstruction bundle: the ROM word and instruction register fields in, the registered datapath controls out.
interface control_signals_if;
  logic [34:0] ROMIN;
  logic [3:0]  WR;
  logic [3:0]  RR;
  logic [15:0] WE;
  logic [15:0] RE;
  logic [11:0] CTL;
  logic [2:0]  ALUMUX;
  logic [2:0]  ALUCTRL;
  logic [4:0]  NXTADD;

  modport master (
    output ROMIN, WR, RR,
    input  WE, RE, CTL, ALUMUX, ALUCTRL, NXTADD
  );

  modport slave (
    input  ROMIN, WR, RR,
    output WE, RE, CTL, ALUMUX, ALUCTRL, NXTADD
  );
endinterface

// File: rtl/control_signals.sv
// Decodes a control-ROM microinstruction into registered one-hot write/read enables plus pass-through fields.
// Optional macro CTRLSIG_ZERO_REG_EN: WE0 is never asserted, so register 0 is read-only.
module control_signals (
  input logic              clk,
  input logic              reset_n,
  control_signals_if.slave bus
);
  // ROMIN field slices
  logic [4:0]  nxtadd_f;
  logic [2:0]  aluctrl_f;
  logic [2:0]  alumux_f;
  logic        wen, wsrc, ren, rsrc;
  logic [3:0]  wsel, rsel;
  logic [11:0] ctl_f;

  assign nxtadd_f  = bus.ROMIN[34:30];
  assign aluctrl_f = bus.ROMIN[29:27];
  assign alumux_f  = bus.ROMIN[26:24];
  assign wen       = bus.ROMIN[23];
  assign wsrc      = bus.ROMIN[22];
  assign wsel      = bus.ROMIN[21:18];
  assign ren       = bus.ROMIN[17];
  assign rsrc      = bus.ROMIN[16];
  assign rsel      = bus.ROMIN[15:12];
  assign ctl_f     = bus.ROMIN[11:0];

  logic [3:0]  wr_idx, rd_idx;
  logic [15:0] we_d, re_d;

  always_comb begin
    wr_idx = wsrc ? bus.WR : wsel;
    rd_idx = rsrc ? bus.RR : rsel;
    we_d   = '0;
    re_d   = '0;
    if (wen) we_d[wr_idx] = 1'b1;
    if (ren) re_d[rd_idx] = 1'b1;
`ifdef CTRLSIG_ZERO_REG_EN
    we_d[0] = 1'b0;
`else
    we_d[0] = we_d[0];
`endif
  end

  logic [15:0] we_q, re_q;
  logic [11:0] ctl_q;
  logic [2:0]  alumux_q, aluctrl_q;
  logic [4:0]  nxtadd_q;

  // Reset forces NXTADD to 0 so the sequencer restarts at microaddress 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= '0;
      re_q      <= '0;
      ctl_q     <= '0;
      alumux_q  <= '0;
      aluctrl_q <= '0;
      nxtadd_q  <= '0;
    end else begin
      we_q      <= we_d;
      re_q      <= re_d;
      ctl_q     <= ctl_f;
      alumux_q  <= alumux_f;
      aluctrl_q <= aluctrl_f;
      nxtadd_q  <= nxtadd_f;
    end
  end

  assign bus.WE      = we_q;
  assign bus.RE      = re_q;
  assign bus.CTL     = ctl_q;
  assign bus.ALUMUX  = alumux_q;
  assign bus.ALUCTRL = aluctrl_q;
  assign bus.NXTADD  = nxtadd_q;
endmodule

// File: tb/tb_control_signals.sv
// Directed + random bench for control_signals; expected words are queued at drive time and popped after the edge.
module tb_control_signals;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  logic [54:0] sb_q[$];
  logic [54:0] last_exp;

  control_signals_if bus();

  control_signals dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
    $fatal(1, "timeout");
  end

  function automatic logic [34:0] mk(input logic [4:0] nxt, input logic [2:0] aluc,
                                     input logic [2:0] alum, input logic wen, input logic wsrc,
                                     input logic [3:0] wsel, input logic ren, input logic rsrc,
                                     input logic [3:0] rsel, input logic [11:0] ctl);
    return {nxt, aluc, alum, wen, wsrc, wsel, ren, rsrc, rsel, ctl};
  endfunction

  function automatic logic [54:0] model(input logic [34:0] r, input logic [3:0] wr, input logic [3:0] rr);
    logic [15:0] we;
    logic [15:0] re;
    we = 16'h0000;
    re = 16'h0000;
    if (r[23]) we = 16'h0001 << (r[22] ? wr : r[21:18]);
    if (r[17]) re = 16'h0001 << (r[16] ? rr : r[15:12]);
`ifdef CTRLSIG_ZERO_REG_EN
    we = we & 16'hFFFE;
`endif
    return {we, re, r[11:0], r[26:24], r[29:27], r[34:30]};
  endfunction

  function automatic logic [54:0] outvec();
    return {bus.WE, bus.RE, bus.CTL, bus.ALUMUX, bus.ALUCTRL, bus.NXTADD};
  endfunction

  task automatic check(input string tag, input logic [54:0] obs, input logic [54:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a word at the falling edge, queue its expectation, compare just after the rising edge.
  task automatic step(input string tag, input logic [34:0] r, input logic [3:0] wr, input logic [3:0] rr);
    logic [54:0] exp;
    @(negedge clk);
    bus.ROMIN = r;
    bus.WR    = wr;
    bus.RR    = rr;
    sb_q.push_back(model(r, wr, rr));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      exp = sb_q.pop_front();
      last_exp = exp;
      check(tag, outvec(), exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    last_exp = '0;
    reset_n  = 1'b0;
    bus.ROMIN = '0;
    bus.WR    = '0;
    bus.RR    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outvec(), 55'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Pass-through fields with both decoders disabled
    step("passthru", mk(5'b10110, 3'b101, 3'b011, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd9, 12'hA5C), 4'd5, 4'd6);
    check("passthru_fields", {bus.NXTADD, bus.ALUCTRL, bus.ALUMUX, bus.CTL, bus.WE, bus.RE},
          {5'b10110, 3'b101, 3'b011, 12'hA5C, 16'h0000, 16'h0000});

    // Indices from the instruction fields
    step("instr_ops", mk(5'd1, 3'd0, 3'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd4, 12'h000), 4'b1100, 4'b0001);
    check("instr_ops_en", {bus.WE, bus.RE}, {16'h1000, 16'h0002});

    // Indices from the microword; WR/RR must be ignored
    step("micro_sel", mk(5'd2, 3'd1, 3'd2, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0, 4'b1111, 12'h123), 4'd2, 4'd3);
    check("micro_sel_en", {bus.WE, bus.RE}, {16'h0080, 16'h8000});

    // Same register read and write enabled together
    step("same_reg", mk(5'd31, 3'd7, 3'd7, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 4'd5, 12'hFFF), 4'd0, 4'd0);

    // Register 0 via WSEL and via WR; RE0 is never suppressed
    step("we0_wsel", mk(5'd3, 3'd2, 3'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 12'h00F), 4'd9, 4'd9);
`ifdef CTRLSIG_ZERO_REG_EN
    check("we0_macro", {bus.WE[0], bus.RE[0]}, 2'b01);
`else
    check("we0_macro", {bus.WE[0], bus.RE[0]}, 2'b11);
`endif
    step("we0_wr", mk(5'd4, 3'd3, 3'd4, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 12'h800), 4'd0, 4'd0);

    // Mid-cycle input change must not reach the outputs before the edge
    @(negedge clk);
    bus.ROMIN = mk(5'd9, 3'd6, 3'd5, 1'b1, 1'b0, 4'd14, 1'b1, 1'b0, 4'd13, 12'h3C3);
    #2;
    check("hold_midcycle", outvec(), last_exp);
    sb_q.push_back(model(bus.ROMIN, bus.WR, bus.RR));
    @(posedge clk);
    #1;
    last_exp = sb_q.pop_front();
    check("hold_then_load", outvec(), last_exp);

    // Asynchronous reset mid-cycle, then the in-flight word is discarded
    @(negedge clk);
    bus.ROMIN = mk(5'd17, 3'd1, 3'd1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 4'd2, 12'h555);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", outvec(), 55'd0);
    @(posedge clk);
    #1;
    check("reset_held", outvec(), 55'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.push_back(model(bus.ROMIN, bus.WR, bus.RR));
    @(posedge clk);
    #1;
    last_exp = sb_q.pop_front();
    check("post_reset_load", outvec(), last_exp);

    // Random words
    for (int i = 0; i < 24; i++) begin
      step("random", 35'($urandom) | (35'($urandom_range(0, 7)) << 32), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
